sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one single-port, bit-write-enabled SRAM macro (active-low CEN/WEN/BWEN,
//  1-cycle registered read) between two requesters: req0 (cache lookup) and req1
//  (refill/writeback). After reset it zero-fills every entry, then arbitrates
//  round-robin. It translates byte strobes into the macro's per-bit write mask.
//  It sits between the cache controller and each data/tag array macro.
// PARAMETERS
//  DATA_W  128  SRAM word width; must be a multiple of 8
//  DEPTH   64   number of SRAM words
//  ADDR_W  6    address width; equals $clog2(DEPTH)
//  STRB_W  16   byte strobes per word; equals DATA_W/8 (derived, not overridden)
// PORTS
//  i_clk          in   1       clock; all state updates on the rising edge
//  i_rst          in   1       synchronous reset, active-high
//  i_reqN_valid   in   1       requester N (N=0,1) has a request
//  o_reqN_ready   out  1       request N accepted this cycle
//  i_reqN_wen     in   1       1=write, 0=read
//  i_reqN_addr    in   ADDR_W  word address
//  i_reqN_wdata   in   DATA_W  write data
//  i_reqN_wstrb   in   STRB_W  byte enables; bit b covers data[8b+7:8b]
//  o_rspN_valid   out  1       read data for requester N is valid this cycle
//  o_rspN_rdata   out  DATA_W  read data; meaningful only while o_rspN_valid=1
//  o_sram_cen     out  1       macro chip enable, active-low
//  o_sram_wen     out  1       macro write enable, active-low
//  o_sram_bwen    out  DATA_W  macro bit write mask, active-low
//  o_sram_a       out  ADDR_W  macro address
//  o_sram_d       out  DATA_W  macro write data
//  i_sram_q       in   DATA_W  macro read data, registered by the macro
//  o_init_done    out  1       zero-fill complete; requests are accepted
// BEHAVIOUR
//  Reset (i_rst=1 at the edge):
//   - state=INIT, init_addr=0, rr_ptr=0 (req0 preferred), o_init_done=0
//   - o_rsp*_valid=0, and any read in flight is dropped
//  Idle macro drive: cen=1, wen=1, bwen=all-1, a=0, d=0. This drive applies while
//  i_rst=1 and on any RUN cycle with no grant.
//  INIT:
//   - each cycle: cen=0, wen=0, bwen=all-0, a=init_addr, d=0; init_addr++
//   - o_req*_ready=0 regardless of valid
//   - after the write to DEPTH-1 -> RUN; o_init_done=1 from the next cycle onward
//   - INIT lasts exactly DEPTH cycles after reset deassertion
//  RUN arbitration (combinational grant, one grant per cycle):
//   - only one valid: that requester is granted
//   - both valid: the requester rr_ptr points to is granted; rr_ptr then toggles
//     to the other requester. A grant with no contention also sets rr_ptr to the
//     other requester.
//   - o_reqN_ready = grantN. The transfer happens when valid&ready. Ready never
//     asserts without the matching valid.
//   - granted request drives the macro combinationally: cen=0, wen=~wen_req,
//     a=addr, d=wdata
//   - write: bwen[8b+:8] = {8{~wstrb[b]}}
//   - read: bwen=all-1
//  Read response:
//   - a read accepted in cycle T gives o_rspN_valid=1 in T+1 only
//   - o_rspN_rdata = i_sram_q (pass-through, no extra register); no backpressure
//   - reads are pipelined: a read every cycle gives a response every cycle
//  Ordering: a write accepted in T followed by a read of the same address
//  accepted in T+1 returns the new data in T+2.
//  Write with wstrb=0: the macro is still enabled and no bits change; it counts
//  as a grant for round-robin.
//  Reset mid-RUN or mid-INIT: the pending response is suppressed and the zero-fill
//  restarts from address 0.
// STRUCTURE
//  Package cache_sram_pkg:
//   - typedef enum logic {ST_INIT, ST_RUN} sram_arb_state_e
//   - function strb2bwen(wstrb) returning the active-low DATA_W mask
//  Sub-module sram_rr_arb2: 2-way round-robin grant with rr_ptr register
//  (i_clk, i_rst, i_valid[1:0], o_grant[1:0]). The top holds the INIT counter,
//  macro mux and response-valid flops.
// TESTING
//  1 reset, release, no requests -> cen=0/wen=0/bwen=0/d=0 for a=0..63 over 64
//    cycles; o_init_done=1 at cycle 65; req0_valid during INIT sees ready=0
//  2 req0 write addr 5 d=128'hA5.., wstrb=16'hFFFF; next cycle req0 read addr 5
//    -> rsp0_valid one cycle later, rdata=128'hA5..
//  3 write addr 7 d=all-1 wstrb=16'h0001 after init -> read addr 7 returns
//    128'h0000..00FF; bwen during the write = {120{1'b1},8'h00}
//  4 req0 and req1 reads held valid 6 cycles -> grants alternate 0,1,0,1,0,1;
//    each rsp valid only on its own requester, 1 cycle after its grant
//  5 req1 alone for 3 cycles then both valid -> req0 granted first (ptr moved
//    to 0 after the last req1 grant)
//  6 assert i_rst at INIT addr 30, or the cycle after a read grant -> no
//    rsp_valid; INIT restarts at a=0; o_init_done=0 until 64 cycles after release

Source files
------------

// File: rtl/cache_sram_pkg.sv
// Shared types and helpers for the cache SRAM port arbiter.
package cache_sram_pkg;

  localparam int unsigned CACHE_DATA_W = 128;
  localparam int unsigned CACHE_STRB_W = CACHE_DATA_W / 8;

  typedef enum logic {ST_INIT, ST_RUN} sram_arb_state_e;

  // Byte strobes to the macro's active-low per-bit write mask.
  function automatic logic [CACHE_DATA_W-1:0] strb2bwen(input logic [CACHE_STRB_W-1:0] wstrb);
    logic [CACHE_DATA_W-1:0] bwen;
    bwen = '1;
    for (int b = 0; b < int'(CACHE_STRB_W); b++) begin
      bwen[8*b +: 8] = {8{~wstrb[b]}};
    end
    return bwen;
  endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin grant; the pointer always moves away from the last winner.
module sram_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

  logic       rr_ptr_q;
  logic       rr_ptr_d;
  logic [1:0] grant;

  always_comb begin
    grant    = i_valid;
    rr_ptr_d = rr_ptr_q;
    if (&i_valid) begin
      grant = rr_ptr_q ? 2'b10 : 2'b01;
    end
    if (grant[0]) begin
      rr_ptr_d = 1'b1;
    end else if (grant[1]) begin
      rr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign o_grant = grant;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM macro between a lookup and a refill requester,
// zero-filling the array after reset.
//   state   | meaning
//   ST_INIT | writing zero to one entry per cycle, requests held off
//   ST_RUN  | round-robin service of req0/req1
module sram_port_arbiter
  import cache_sram_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req0_valid,
  output logic                o_req0_ready,
  input  logic                i_req0_wen,
  input  logic [ADDR_W-1:0]   i_req0_addr,
  input  logic [DATA_W-1:0]   i_req0_wdata,
  input  logic [DATA_W/8-1:0] i_req0_wstrb,
  input  logic                i_req1_valid,
  output logic                o_req1_ready,
  input  logic                i_req1_wen,
  input  logic [ADDR_W-1:0]   i_req1_addr,
  input  logic [DATA_W-1:0]   i_req1_wdata,
  input  logic [DATA_W/8-1:0] i_req1_wstrb,
  output logic                o_rsp0_valid,
  output logic [DATA_W-1:0]   o_rsp0_rdata,
  output logic                o_rsp1_valid,
  output logic [DATA_W-1:0]   o_rsp1_rdata,
  output logic                o_sram_cen,
  output logic                o_sram_wen,
  output logic [DATA_W-1:0]   o_sram_bwen,
  output logic [ADDR_W-1:0]   o_sram_a,
  output logic [DATA_W-1:0]   o_sram_d,
  input  logic [DATA_W-1:0]   i_sram_q,
  output logic                o_init_done
);

  sram_arb_state_e   state_q, state_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [1:0]        grant;
  logic              run;
  logic              req_wen;

  // Reset overrides everything combinationally so the macro sees idle drive.
  assign run = (state_q == ST_RUN) && !i_rst;

  sram_rr_arb2 u_arb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid ({i_req1_valid, i_req0_valid} & {2{run}}),
    .o_grant (grant)
  );

  assign req_wen = grant[1] ? i_req1_wen : i_req0_wen;

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == ST_INIT) begin
      init_addr_d = init_addr_q + 1'b1;
      if (init_addr_q == ADDR_W'(DEPTH - 1)) begin
        state_d     = ST_RUN;
        init_addr_d = '0;
      end
    end
    rsp_valid_d = grant & ~{i_req1_wen, i_req0_wen};
  end

  always_comb begin
    o_sram_cen  = 1'b1;
    o_sram_wen  = 1'b1;
    o_sram_bwen = '1;
    o_sram_a    = '0;
    o_sram_d    = '0;
    if (!i_rst && state_q == ST_INIT) begin
      o_sram_cen  = 1'b0;
      o_sram_wen  = 1'b0;
      o_sram_bwen = '0;
      o_sram_a    = init_addr_q;
    end else if (|grant) begin
      o_sram_cen  = 1'b0;
      o_sram_wen  = ~req_wen;
      o_sram_a    = grant[1] ? i_req1_addr  : i_req0_addr;
      o_sram_d    = grant[1] ? i_req1_wdata : i_req0_wdata;
      if (req_wen) begin
        o_sram_bwen = strb2bwen(grant[1] ? i_req1_wstrb : i_req0_wstrb);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign o_req0_ready = grant[0];
  assign o_req1_ready = grant[1];
  assign o_rsp0_valid = rsp_valid_q[0] && !i_rst;
  assign o_rsp1_valid = rsp_valid_q[1] && !i_rst;
  assign o_rsp0_rdata = i_sram_q;
  assign o_rsp1_rdata = i_sram_q;
  assign o_init_done  = run;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural bit-masked SRAM model.
module tb_sram_port_arbiter;

  localparam logic [127:0] A5   = {16{8'hA5}};
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] FFV  = 128'hFF;
  localparam logic [127:0] Z    = 128'h0;
  localparam logic [127:0] BW3  = {{120{1'b1}}, 8'h00};

  typedef struct {
    logic v0, w0; logic [5:0] a0; logic [127:0] d0; logic [15:0] s0;
    logic v1, w1; logic [5:0] a1; logic [127:0] d1; logic [15:0] s1;
    logic r0, r1, cen, wen; logic [5:0] ea; logic [127:0] ebwen, ed;
    logic p0, p1; logic [127:0] erd;
  } vec_t;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_req0_valid, i_req0_wen, i_req1_valid, i_req1_wen;
  logic [5:0]   i_req0_addr, i_req1_addr;
  logic [127:0] i_req0_wdata, i_req1_wdata;
  logic [15:0]  i_req0_wstrb, i_req1_wstrb;
  logic         o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid;
  logic [127:0] o_rsp0_rdata, o_rsp1_rdata;
  logic         o_sram_cen, o_sram_wen, o_init_done;
  logic [127:0] o_sram_bwen, o_sram_d, sram_q;
  logic [5:0]   o_sram_a;

  logic [127:0] mem [64];
  logic         scramble;
  int           checks = 0;
  int           errors = 0;
  vec_t         vecs [25];

  always #5 i_clk = ~i_clk;

  sram_port_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready), .i_req0_wen(i_req0_wen),
    .i_req0_addr(i_req0_addr), .i_req0_wdata(i_req0_wdata), .i_req0_wstrb(i_req0_wstrb),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready), .i_req1_wen(i_req1_wen),
    .i_req1_addr(i_req1_addr), .i_req1_wdata(i_req1_wdata), .i_req1_wstrb(i_req1_wstrb),
    .o_rsp0_valid(o_rsp0_valid), .o_rsp0_rdata(o_rsp0_rdata),
    .o_rsp1_valid(o_rsp1_valid), .o_rsp1_rdata(o_rsp1_rdata),
    .o_sram_cen(o_sram_cen), .o_sram_wen(o_sram_wen), .o_sram_bwen(o_sram_bwen),
    .o_sram_a(o_sram_a), .o_sram_d(o_sram_d), .i_sram_q(sram_q), .o_init_done(o_init_done)
  );

  // Macro model: garbage contents until the DUT's zero-fill, 1-cycle registered read.
  always @(posedge i_clk) begin
    if (scramble) begin
      for (int i = 0; i < 64; i++) mem[i] <= {4{32'hDEADBEEF ^ 32'(i)}};
    end else if (!o_sram_cen) begin
      if (!o_sram_wen) mem[o_sram_a] <= (mem[o_sram_a] & o_sram_bwen) | (o_sram_d & ~o_sram_bwen);
      else sram_q <= mem[o_sram_a];
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_idle();
    i_req0_valid = 0; i_req0_wen = 0; i_req0_addr = 0; i_req0_wdata = Z; i_req0_wstrb = 0;
    i_req1_valid = 0; i_req1_wen = 0; i_req1_addr = 0; i_req1_wdata = Z; i_req1_wstrb = 0;
  endtask

  function automatic vec_t mk(
    logic v0, w0, logic [5:0] a0, logic [127:0] d0, logic [15:0] s0,
    logic v1, w1, logic [5:0] a1, logic [127:0] d1, logic [15:0] s1,
    logic r0, r1, cen, wen, logic [5:0] ea, logic [127:0] ebwen, ed,
    logic p0, p1, logic [127:0] erd);
    vec_t v;
    v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.s0 = s0;
    v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.s1 = s1;
    v.r0 = r0; v.r1 = r1; v.cen = cen; v.wen = wen; v.ea = ea; v.ebwen = ebwen; v.ed = ed;
    v.p0 = p0; v.p1 = p1; v.erd = erd;
    return v;
  endfunction

  // Bounded wait per INIT phase: exactly DEPTH cycles with incrementing address.
  task automatic check_init(input string tag, input bit full);
    for (int k = 0; k < 64; k++) begin
      @(negedge i_clk);
      chk($sformatf("%s_a%0d", tag, k), 128'(o_sram_a), 128'(k));
      chk($sformatf("%s_done%0d", tag, k), 128'(o_init_done), 128'(0));
      if (full) begin
        chk($sformatf("%s_cenwen%0d", tag, k), 128'({o_sram_cen, o_sram_wen}), 128'(0));
        chk($sformatf("%s_bwen%0d", tag, k), o_sram_bwen, Z);
        chk($sformatf("%s_d%0d", tag, k), o_sram_d, Z);
        chk($sformatf("%s_rdy%0d", tag, k), 128'({o_req1_ready, o_req0_ready}), 128'(0));
      end
      next_cycle();
    end
    drive_idle();
    @(negedge i_clk);
    chk({tag, "_done_after"}, 128'(o_init_done), 128'(1));
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // v0 w0 a0 d0 s0 | v1 w1 a1 d1 s1 | r0 r1 cen wen a bwen d | p0 p1 rdata
    vecs[0]  = mk(1,1,5,A5,16'hFFFF, 0,0,0,Z,0,         1,0,0,0,5,Z,A5,       0,0,Z);
    vecs[1]  = mk(1,0,5,Z,0,         0,0,0,Z,0,         1,0,0,1,5,ONES,Z,     0,0,Z);
    vecs[2]  = mk(0,0,0,Z,0,         0,0,0,Z,0,         0,0,1,1,0,ONES,Z,     1,0,A5);
    vecs[3]  = mk(0,0,0,Z,0,         1,1,7,ONES,16'h1,  0,1,0,0,7,BW3,ONES,   0,0,Z);
    vecs[4]  = mk(0,0,0,Z,0,         1,0,7,Z,0,         0,1,0,1,7,ONES,Z,     0,0,Z);
    vecs[5]  = mk(0,0,0,Z,0,         0,0,0,Z,0,         0,0,1,1,0,ONES,Z,     0,1,FFV);
    vecs[6]  = mk(1,0,5,Z,0,         1,0,7,Z,0,         1,0,0,1,5,ONES,Z,     0,0,Z);
    vecs[7]  = mk(1,0,5,Z,0,         1,0,7,Z,0,         0,1,0,1,7,ONES,Z,     1,0,A5);
    vecs[8]  = mk(1,0,5,Z,0,         1,0,7,Z,0,         1,0,0,1,5,ONES,Z,     0,1,FFV);
    vecs[9]  = mk(1,0,5,Z,0,         1,0,7,Z,0,         0,1,0,1,7,ONES,Z,     1,0,A5);
    vecs[10] = mk(1,0,5,Z,0,         1,0,7,Z,0,         1,0,0,1,5,ONES,Z,     0,1,FFV);
    vecs[11] = mk(1,0,5,Z,0,         1,0,7,Z,0,         0,1,0,1,7,ONES,Z,     1,0,A5);
    vecs[12] = mk(0,0,0,Z,0,         0,0,0,Z,0,         0,0,1,1,0,ONES,Z,     0,1,FFV);
    vecs[13] = mk(1,0,5,Z,0,         0,0,0,Z,0,         1,0,0,1,5,ONES,Z,     0,0,Z);
    vecs[14] = mk(0,0,0,Z,0,         1,0,7,Z,0,         0,1,0,1,7,ONES,Z,     1,0,A5);
    vecs[15] = mk(0,0,0,Z,0,         1,0,7,Z,0,         0,1,0,1,7,ONES,Z,     0,1,FFV);
    vecs[16] = mk(0,0,0,Z,0,         1,0,7,Z,0,         0,1,0,1,7,ONES,Z,     0,1,FFV);
    vecs[17] = mk(1,0,5,Z,0,         1,0,7,Z,0,         1,0,0,1,5,ONES,Z,     0,1,FFV);
    vecs[18] = mk(0,0,0,Z,0,         0,0,0,Z,0,         0,0,1,1,0,ONES,Z,     1,0,A5);
    vecs[19] = mk(1,1,5,ONES,0,      0,0,0,Z,0,         1,0,0,0,5,ONES,ONES,  0,0,Z);
    vecs[20] = mk(1,0,5,Z,0,         1,0,7,Z,0,         0,1,0,1,7,ONES,Z,     0,0,Z);
    vecs[21] = mk(1,0,5,Z,0,         0,0,0,Z,0,         1,0,0,1,5,ONES,Z,     0,1,FFV);
    vecs[22] = mk(0,0,0,Z,0,         0,0,0,Z,0,         0,0,1,1,0,ONES,Z,     1,0,A5);
    vecs[23] = mk(0,0,0,Z,0,         1,0,9,Z,0,         0,1,0,1,9,ONES,Z,     0,0,Z);
    vecs[24] = mk(0,0,0,Z,0,         0,0,0,Z,0,         0,0,1,1,0,ONES,Z,     0,1,Z);

    drive_idle();
    i_rst = 1;
    scramble = 1;
    repeat (2) next_cycle();
    scramble = 0;
    next_cycle();
    @(negedge i_clk);
    chk("rst_cen", 128'(o_sram_cen), 128'(1));
    chk("rst_bwen", o_sram_bwen, ONES);
    chk("rst_done", 128'(o_init_done), 128'(0));
    chk("rst_rsp", 128'({o_rsp1_valid, o_rsp0_valid}), 128'(0));
    next_cycle();
    i_rst = 0;
    i_req0_valid = 1;
    check_init("init", 1);

    foreach (vecs[i]) begin
      i_req0_valid = vecs[i].v0; i_req0_wen = vecs[i].w0; i_req0_addr = vecs[i].a0;
      i_req0_wdata = vecs[i].d0; i_req0_wstrb = vecs[i].s0;
      i_req1_valid = vecs[i].v1; i_req1_wen = vecs[i].w1; i_req1_addr = vecs[i].a1;
      i_req1_wdata = vecs[i].d1; i_req1_wstrb = vecs[i].s1;
      @(negedge i_clk);
      chk($sformatf("v%0d_ready", i), 128'({o_req1_ready, o_req0_ready}), 128'({vecs[i].r1, vecs[i].r0}));
      chk($sformatf("v%0d_cenwen", i), 128'({o_sram_cen, o_sram_wen}), 128'({vecs[i].cen, vecs[i].wen}));
      chk($sformatf("v%0d_a", i), 128'(o_sram_a), 128'(vecs[i].ea));
      chk($sformatf("v%0d_bwen", i), o_sram_bwen, vecs[i].ebwen);
      chk($sformatf("v%0d_d", i), o_sram_d, vecs[i].ed);
      chk($sformatf("v%0d_rspv", i), 128'({o_rsp1_valid, o_rsp0_valid}), 128'({vecs[i].p1, vecs[i].p0}));
      if (vecs[i].p0) chk($sformatf("v%0d_rdata0", i), o_rsp0_rdata, vecs[i].erd);
      if (vecs[i].p1) chk($sformatf("v%0d_rdata1", i), o_rsp1_rdata, vecs[i].erd);
      next_cycle();
    end
    drive_idle();

    // Reset mid-INIT at address 30, then a full restart from 0.
    i_rst = 1;
    next_cycle();
    i_rst = 0;
    repeat (30) next_cycle();
    @(negedge i_clk);
    chk("midinit_a30", 128'(o_sram_a), 128'(30));
    next_cycle();
    i_rst = 1;
    @(negedge i_clk);
    chk("midinit_rst_cen", 128'(o_sram_cen), 128'(1));
    chk("midinit_rst_a", 128'(o_sram_a), 128'(0));
    next_cycle();
    i_rst = 0;
    check_init("reinit", 0);

    // Reset the cycle after a read grant: the response must never appear.
    i_req0_valid = 1; i_req0_wen = 0; i_req0_addr = 5;
    @(negedge i_clk);
    chk("rdrst_grant", 128'(o_req0_ready), 128'(1));
    next_cycle();
    drive_idle();
    i_rst = 1;
    @(negedge i_clk);
    chk("rdrst_rsp_in_rst", 128'({o_rsp1_valid, o_rsp0_valid}), 128'(0));
    next_cycle();
    i_rst = 0;
    @(negedge i_clk);
    chk("rdrst_rsp_after", 128'({o_rsp1_valid, o_rsp0_valid}), 128'(0));
    chk("rdrst_init_a0", 128'({o_sram_cen, o_sram_a}), 128'(0));
    chk("rdrst_done", 128'(o_init_done), 128'(0));
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
